// File: rtl/kmeans_pkg.sv
`default_nettype none
// ============================================================================
// Package  : kmeans_pkg
// Brief    : FSM encoding and width helpers for the k-means engine.
//            KMEANS_SQ_DIST_EN widens the distance and deepens the pipeline.
// Revision : 1.0
// ============================================================================
package kmeans_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

`ifdef KMEANS_SQ_DIST_EN
  localparam int c_PIPE_DEPTH = 4;
`else
  localparam int c_PIPE_DEPTH = 3;
`endif

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  function automatic int dist_w(input int data_w, input int n);
`ifdef KMEANS_SQ_DIST_EN
    return 2 * data_w + clog2(n);
`else
    return data_w + clog2(n);
`endif
  endfunction

  function automatic int acc_w(input int data_w, input int qty_w);
    return data_w + qty_w + 1;
  endfunction

  function automatic int cnt_w(input int qty_w);
    return qty_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kmeans_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_seq_div
// Brief    : Restoring unsigned divider, one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
module kmeans_seq_div
  import kmeans_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quotient
);

  localparam int c_CW = clog2(W + 1);

  logic [W-1:0]    r_quo;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_div;
  logic [c_CW-1:0] r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [W:0]      w_shift;
  logic [W-1:0]    w_sub;
  logic            w_ge;

  // The remainder is always below the divisor, so the low W bits of the
  // difference are exact whenever the subtraction is taken.
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_sub   = w_shift[W-1:0] - r_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_quo  <= i_dividend;
        r_rem  <= '0;
        r_div  <= i_divisor;
        r_cnt  <= c_CW'(W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_ge ? w_sub : w_shift[W-1:0];
        r_quo <= {r_quo[W-2:0], w_ge};
        r_cnt <= r_cnt - c_CW'(1);
        if (r_cnt == c_CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/kmeans_kn_engine.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_kn_engine
// Brief    : K-cluster, N-dimension k-means engine fed from a sync point memory.
//            Define KMEANS_SQ_DIST_EN for squared-Euclidean distance (else L1).
// Revision : 1.0
// ============================================================================
module kmeans_kn_engine
  import kmeans_pkg::*;
#(
  parameter int                    K         = 2,
  parameter int                    N         = 5,
  parameter int                    DATA_W    = 8,
  parameter int                    QTY_W     = 8,
  parameter int                    QTY       = 256,
  parameter int                    MAX_ITER  = 16,
  parameter logic [K*N*DATA_W-1:0] CENT_INIT = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  output logic                         o_rd_en,
  output logic [QTY_W-1:0]             o_rd_addr,
  input  logic [N*DATA_W-1:0]          i_rd_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_converged,
  output logic [clog2(MAX_ITER+1)-1:0] o_iter_count,
  output logic [K*N*DATA_W-1:0]        o_centroids
);

  localparam int c_NC     = K * N;
  localparam int c_DIST_W = dist_w(DATA_W, N);
  localparam int c_ACC_W  = acc_w(DATA_W, QTY_W);
  localparam int c_CNT_W  = cnt_w(QTY_W);
  localparam int c_IT_W   = clog2(MAX_ITER + 1);
  localparam int c_KW     = clog2(K);
  localparam int c_DW     = (N > 1) ? clog2(N) : 1;
  localparam int c_IW     = clog2(c_NC);

  state_t                r_state, w_next;
  logic [c_CNT_W-1:0]    r_fcnt;
  logic [2:0]            r_drain;
  logic [c_KW-1:0]       r_uk;
  logic [c_DW-1:0]       r_ud;
  logic [c_IW-1:0]       w_uidx;
  logic                  r_uwait, r_changed, r_done, r_conv;
  logic [c_IT_W-1:0]     r_iter;
  logic [DATA_W-1:0]     r_cent [c_NC];
  logic [c_ACC_W-1:0]    r_sum  [c_NC];
  logic [c_CNT_W-1:0]    r_cnt  [K];
  logic                  r_rdv, r_s0v, r_s1v, w_s1_v;
  logic [N*DATA_W-1:0]   r_p0, r_p1, w_s1_p;
  logic [c_DIST_W-1:0]   w_dist [K];
  logic [c_DIST_W-1:0]   r_dist [K];
  logic [c_KW-1:0]       w_best;
  logic [c_DIST_W-1:0]   w_bestd;
  logic                  w_cnt_zero, w_div_start, w_div_busy, w_div_done;
  logic                  w_upd_adv, w_upd_last;
  logic [c_ACC_W-1:0]    w_quo;

  function automatic logic [DATA_W-1:0] absdiff(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_busy  = 1'b1;
    o_rd_en = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        o_busy = 1'b0;
        if (i_start) w_next = ST_CLEAR;
      end
      ST_CLEAR: w_next = ST_FETCH;
      ST_FETCH: begin
        o_rd_en = 1'b1;
        if (r_fcnt == c_CNT_W'(QTY - 1)) w_next = ST_DRAIN;
      end
      ST_DRAIN:  if (r_drain == 3'(c_PIPE_DEPTH - 1)) w_next = ST_UPDATE;
      ST_UPDATE: if (w_upd_adv && w_upd_last) w_next = ST_CHECK;
      ST_CHECK:  w_next = (!r_changed || (r_iter == c_IT_W'(MAX_ITER - 1))) ? ST_DONE : ST_CLEAR;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Update walk: empty clusters advance immediately, others wait on the divider.
  assign w_uidx      = c_IW'(int'(r_uk) * N + int'(r_ud));
  assign w_cnt_zero  = (r_cnt[r_uk] == '0);
  assign w_div_start = (r_state == ST_UPDATE) && !r_uwait && !w_cnt_zero && !w_div_busy;
  assign w_upd_adv   = (r_state == ST_UPDATE) && (r_uwait ? w_div_done : w_cnt_zero);
  assign w_upd_last  = (r_uk == c_KW'(K - 1)) && (r_ud == c_DW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt    <= '0;
      r_drain   <= '0;
      r_uk      <= '0;
      r_ud      <= '0;
      r_uwait   <= 1'b0;
      r_changed <= 1'b0;
      r_iter    <= '0;
      r_done    <= 1'b0;
      r_conv    <= 1'b0;
      for (int i = 0; i < c_NC; i++) r_cent[i] <= CENT_INIT[i*DATA_W +: DATA_W];
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_iter <= '0;
            r_done <= 1'b0;
            r_conv <= 1'b0;
            for (int i = 0; i < c_NC; i++) r_cent[i] <= CENT_INIT[i*DATA_W +: DATA_W];
          end
        end
        ST_CLEAR: begin
          r_fcnt    <= '0;
          r_drain   <= '0;
          r_uk      <= '0;
          r_ud      <= '0;
          r_uwait   <= 1'b0;
          r_changed <= 1'b0;
        end
        ST_FETCH: r_fcnt  <= r_fcnt + c_CNT_W'(1);
        ST_DRAIN: r_drain <= r_drain + 3'd1;
        ST_UPDATE: begin
          if (w_div_start) r_uwait <= 1'b1;
          if (w_upd_adv) begin
            r_uwait <= 1'b0;
            if (r_uwait) begin
              r_cent[w_uidx] <= w_quo[DATA_W-1:0];
              if (w_quo != c_ACC_W'(r_cent[w_uidx])) r_changed <= 1'b1;
            end
            if (r_ud == c_DW'(N - 1)) begin
              r_ud <= '0;
              r_uk <= r_uk + c_KW'(1);
            end else begin
              r_ud <= r_ud + c_DW'(1);
            end
          end
        end
        ST_CHECK: begin
          r_iter <= r_iter + c_IT_W'(1);
          if (w_next == ST_DONE) begin
            r_done <= 1'b1;
            r_conv <= !r_changed;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KMEANS_SQ_DIST_EN
  logic [DATA_W-1:0]   w_adiff [c_NC];
  logic [DATA_W-1:0]   r_adiff [c_NC];
  logic                r_sav;
  logic [N*DATA_W-1:0] r_pa;

  always_comb begin
    for (int k = 0; k < K; k++)
      for (int d = 0; d < N; d++)
        w_adiff[k*N+d] = absdiff(r_p0[d*DATA_W +: DATA_W], r_cent[k*N+d]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sav <= 1'b0;
      r_pa  <= '0;
      for (int i = 0; i < c_NC; i++) r_adiff[i] <= '0;
    end else begin
      r_sav   <= r_s0v;
      r_pa    <= r_p0;
      r_adiff <= w_adiff;
    end
  end

  always_comb begin
    for (int k = 0; k < K; k++) begin
      w_dist[k] = '0;
      for (int d = 0; d < N; d++)
        w_dist[k] = w_dist[k] + c_DIST_W'(r_adiff[k*N+d]) * c_DIST_W'(r_adiff[k*N+d]);
    end
  end

  assign w_s1_v = r_sav;
  assign w_s1_p = r_pa;
`else
  always_comb begin
    for (int k = 0; k < K; k++) begin
      w_dist[k] = '0;
      for (int d = 0; d < N; d++)
        w_dist[k] = w_dist[k] + c_DIST_W'(absdiff(r_p0[d*DATA_W +: DATA_W], r_cent[k*N+d]));
    end
  end

  assign w_s1_v = r_s0v;
  assign w_s1_p = r_p0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdv <= 1'b0;
      r_s0v <= 1'b0;
      r_s1v <= 1'b0;
      r_p0  <= '0;
      r_p1  <= '0;
      for (int k = 0; k < K; k++) r_dist[k] <= '0;
    end else begin
      r_rdv  <= o_rd_en;
      r_s0v  <= r_rdv;
      r_p0   <= i_rd_data;
      r_s1v  <= w_s1_v;
      r_p1   <= w_s1_p;
      r_dist <= w_dist;
    end
  end

  // Strict less-than keeps the lowest cluster index on ties.
  always_comb begin
    w_best  = '0;
    w_bestd = r_dist[0];
    for (int k = 1; k < K; k++) begin
      if (r_dist[k] < w_bestd) begin
        w_bestd = r_dist[k];
        w_best  = c_KW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_CLEAR)) begin
      for (int i = 0; i < c_NC; i++) r_sum[i] <= '0;
      for (int k = 0; k < K; k++) r_cnt[k] <= '0;
    end else if (r_s1v) begin
      for (int k = 0; k < K; k++) begin
        if (w_best == c_KW'(k)) begin
          r_cnt[k] <= r_cnt[k] + c_CNT_W'(1);
          for (int d = 0; d < N; d++)
            r_sum[k*N+d] <= r_sum[k*N+d] + c_ACC_W'(r_p1[d*DATA_W +: DATA_W]);
        end
      end
    end
  end

  kmeans_seq_div #(
    .W (c_ACC_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (r_sum[w_uidx]),
    .i_divisor  (c_ACC_W'(r_cnt[r_uk])),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  generate
    for (genvar i = 0; i < c_NC; i++) begin : g_pack
      assign o_centroids[i*DATA_W +: DATA_W] = r_cent[i];
    end
  endgenerate

  assign o_rd_addr    = r_fcnt[QTY_W-1:0];
  assign o_done       = r_done;
  assign o_converged  = r_conv;
  assign o_iter_count = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_kmeans_kn_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_kmeans_kn_engine
// Brief    : Directed bench for kmeans_kn_engine (four K=2,N=2 configurations).
// Revision : 1.0
// ============================================================================
module tb_kmeans_kn_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       start = '0;
  logic [3:0]       rd_en, busy, done, conv;
  logic [3:0][1:0]  rd_addr;
  logic [3:0][15:0] rd_data = '0;
  logic [3:0][31:0] cent;
  logic [4:0]       it_a, it_c;
  logic             it_b, it_d;
  logic [3:0][7:0]  iter;
  logic [15:0]      mem [4][4];
  int               n_checks = 0;
  int               n_errors = 0;
  int               exp_addr = 0;

`ifdef KMEANS_SQ_DIST_EN
  localparam int          IT_A  = 3;
  localparam logic [31:0] EXP_B = 32'h4244_0000;
  localparam logic [31:0] EXP_D = 32'h0003_0000;
`else
  localparam int          IT_A  = 2;
  localparam logic [31:0] EXP_B = 32'h6465_0001;
  localparam logic [31:0] EXP_D = 32'h0202_0003;
`endif

  assign iter[0] = 8'(it_a);
  assign iter[1] = 8'(it_b);
  assign iter[2] = 8'(it_c);
  assign iter[3] = 8'(it_d);

  kmeans_kn_engine #(.K(2), .N(2), .DATA_W(8), .QTY_W(2), .QTY(4), .MAX_ITER(16),
                     .CENT_INIT(32'h0101_0000)) u_dut_a (
    .clk(clk), .rst(rst), .i_start(start[0]), .o_rd_en(rd_en[0]), .o_rd_addr(rd_addr[0]),
    .i_rd_data(rd_data[0]), .o_busy(busy[0]), .o_done(done[0]), .o_converged(conv[0]),
    .o_iter_count(it_a), .o_centroids(cent[0]));

  kmeans_kn_engine #(.K(2), .N(2), .DATA_W(8), .QTY_W(2), .QTY(4), .MAX_ITER(1),
                     .CENT_INIT(32'h0101_0000)) u_dut_b (
    .clk(clk), .rst(rst), .i_start(start[1]), .o_rd_en(rd_en[1]), .o_rd_addr(rd_addr[1]),
    .i_rd_data(rd_data[1]), .o_busy(busy[1]), .o_done(done[1]), .o_converged(conv[1]),
    .o_iter_count(it_b), .o_centroids(cent[1]));

  kmeans_kn_engine #(.K(2), .N(2), .DATA_W(8), .QTY_W(2), .QTY(4), .MAX_ITER(16),
                     .CENT_INIT(32'hFFFF_0000)) u_dut_c (
    .clk(clk), .rst(rst), .i_start(start[2]), .o_rd_en(rd_en[2]), .o_rd_addr(rd_addr[2]),
    .i_rd_data(rd_data[2]), .o_busy(busy[2]), .o_done(done[2]), .o_converged(conv[2]),
    .o_iter_count(it_c), .o_centroids(cent[2]));

  kmeans_kn_engine #(.K(2), .N(2), .DATA_W(8), .QTY_W(2), .QTY(1), .MAX_ITER(1),
                     .CENT_INIT(32'h0202_0000)) u_dut_d (
    .clk(clk), .rst(rst), .i_start(start[3]), .o_rd_en(rd_en[3]), .o_rd_addr(rd_addr[3]),
    .i_rd_data(rd_data[3]), .o_busy(busy[3]), .o_done(done[3]), .o_converged(conv[3]),
    .o_iter_count(it_d), .o_centroids(cent[3]));

  always @(posedge clk) begin
    for (int u = 0; u < 4; u++)
      if (rd_en[u]) rd_data[u] <= mem[u][rd_addr[u]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Running monitors: read addresses of unit 0 must count up without gaps.
  always @(negedge clk) begin
    for (int u = 0; u < 4; u++)
      if (busy[u]) check($sformatf("u%0d_busy_with_done", u), 64'(done[u]), 64'd0);
    if (rd_en[0]) begin
      check("u0_rd_addr_seq", 64'(rd_addr[0]), 64'(exp_addr));
      exp_addr++;
    end else begin
      exp_addr = 0;
    end
  end

  task automatic run(input int u, input bit poke);
    int cyc;
    @(negedge clk);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    cyc = 0;
    while (!done[u] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start[u] = poke && (cyc == 3);
    end
    start[u] = 1'b0;
    check($sformatf("u%0d_done_timeout", u), 64'(done[u]), 64'd1);
  endtask

  task automatic expect_result(input int u, input logic [31:0] c, input bit cv, input int it);
    check($sformatf("u%0d_centroids", u), 64'(cent[u]), 64'(c));
    check($sformatf("u%0d_converged", u), 64'(conv[u]), 64'(cv));
    check($sformatf("u%0d_iter_count", u), 64'(iter[u]), 64'(it));
    check($sformatf("u%0d_busy_at_done", u), 64'(busy[u]), 64'd0);
  endtask

  initial begin
    mem[0] = '{16'h0000, 16'h0002, 16'h6464, 16'h6466};
    mem[1] = '{16'h0000, 16'h0002, 16'h6464, 16'h6466};
    mem[2] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    mem[3] = '{16'h0003, 16'h0000, 16'h0000, 16'h0000};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy",      64'(busy[0]),  64'd0);
    check("rst_done",      64'(done[0]),  64'd0);
    check("rst_converged", 64'(conv[0]),  64'd0);
    check("rst_iter",      64'(iter[0]),  64'd0);
    check("rst_rd_en",     64'(rd_en[0]), 64'd0);
    check("rst_cent_a",    64'(cent[0]),  64'h0101_0000);
    check("rst_cent_c",    64'(cent[2]),  64'hFFFF_0000);
    check("rst_cent_d",    64'(cent[3]),  64'h0202_0000);

    // Unit 0 also gets a stray start pulse mid-FETCH.
    run(0, 1'b1);
    expect_result(0, 32'h6465_0001, 1'b1, IT_A);
    run(1, 1'b0);
    expect_result(1, EXP_B, 1'b0, 1);
    run(2, 1'b0);
    expect_result(2, 32'hFFFF_0001, 1'b1, 2);
    run(3, 1'b0);
    expect_result(3, EXP_D, 1'b0, 1);

    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("restart_done_cleared", 64'(done[0]), 64'd0);
    check("restart_busy",         64'(busy[0]), 64'd1);
    check("restart_iter_cleared", 64'(iter[0]), 64'd0);
    check("restart_cent_reload",  64'(cent[0]), 64'h0101_0000);
    @(negedge clk);
    check("restart_fetching", 64'(rd_en[0]), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",  64'(busy[0]),  64'd0);
    check("midrst_rd_en", 64'(rd_en[0]), 64'd0);
    check("midrst_cent",  64'(cent[0]),  64'h0101_0000);
    check("midrst_iter",  64'(iter[0]),  64'd0);

    run(0, 1'b0);
    expect_result(0, 32'h6465_0001, 1'b1, IT_A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
